// File: rtl/seq_gen_pkg.sv
// Shared constants for the serial pattern generator: state codes,
// field widths and the length-clamp helper.
package seq_gen_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_SHIFT = 3'd1;
    localparam logic [STATE_W-1:0] ST_GAP   = 3'd2;
    localparam logic [STATE_W-1:0] ST_DONE  = 3'd3;

    // len and repeat arrive as 4-bit fields; the gap count fits 1..15.
    localparam int LEN_W = 4;
    localparam int REP_W = 4;
    localparam int GAP_W = 4;

    // Requested length saturates at the pattern register width.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l,
                                                   input int unsigned      width);
        if (32'(l) > width) return LEN_W'(width);
        return l;
    endfunction

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter with a zero flag. Decrement saturates at zero
// so a stray dec can never wrap the count.
module seq_down_counter #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    // Load has priority over decrement; reset clears the count.
    always_ff @(posedge clk_i) begin
        if (!rst_ni)                   cnt_q <= '0;
        else if (load_i)               cnt_q <= load_val_i;
        else if (dec_i && cnt_q != '0) cnt_q <= cnt_q - W'(1);
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/seq_gen.sv
// Serial pattern generator: latches a pattern on start, shifts len bits
// out MSB first, repeats with idle gaps, then pulses done for one cycle.
// Every output comes straight from a flop.
module seq_gen
    import seq_gen_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   pattern_i,
    input  logic [LEN_W-1:0]   len_i,
    input  logic [REP_W-1:0]   repeat_i,
    output logic               x_o,
    output logic               valid_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [STATE_W-1:0] s_o
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [WIDTH-1:0]   pat_q, pat_d;   // pattern left-aligned: bit len-1 at MSB
    logic [WIDTH-1:0]   sh_q, sh_d;     // bits still to send, next one at MSB
    logic [LEN_W-1:0]   len_q, len_d;
    logic [REP_W-1:0]   rep_q, rep_d;
    logic               x_q, x_d, valid_q, valid_d, busy_q, busy_d, done_q, done_d;

    logic [LEN_W-1:0]   len_c;
    logic [WIDTH-1:0]   pat_al;

    logic               bit_load, bit_dec, bit_zero;
    logic [LEN_W-1:0]   bit_val;
    logic               gap_load, gap_dec, gap_zero;

    assign len_c  = clamp_len(len_i, WIDTH);
    // Shifting left discards the bits above len-1 and aligns bit len-1 to the MSB.
    assign pat_al = pattern_i << (WIDTH - int'(len_c));

    // Bits remaining after the one currently on x.
    seq_down_counter #(.W(LEN_W)) u_bit_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (bit_load),
        .load_val_i (bit_val),
        .dec_i      (bit_dec),
        .zero_o     (bit_zero)
    );

    // Gap cycles remaining after the current one.
    seq_down_counter #(.W(GAP_W)) u_gap_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (gap_load),
        .load_val_i (GAP_W'(GAP_CYCLES - 1)),
        .dec_i      (gap_dec),
        .zero_o     (gap_zero)
    );

    // Next-state and next-output decode.
    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        sh_d     = sh_q;
        len_d    = len_q;
        rep_d    = rep_q;
        x_d      = x_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        bit_load = 1'b0;
        bit_val  = len_q - LEN_W'(1);
        bit_dec  = 1'b0;
        gap_load = 1'b0;
        gap_dec  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                x_d     = 1'b0;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (start_i) begin
                    pat_d  = pat_al;
                    len_d  = len_c;
                    rep_d  = repeat_i;
                    busy_d = 1'b1;
                    if (len_c != '0) begin
                        state_d  = ST_SHIFT;
                        x_d      = pat_al[WIDTH-1];
                        sh_d     = pat_al << 1;
                        valid_d  = 1'b1;
                        bit_load = 1'b1;
                        bit_val  = len_c - LEN_W'(1);
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end

            ST_SHIFT: begin
                if (!bit_zero) begin
                    bit_dec = 1'b1;
                    x_d     = sh_q[WIDTH-1];
                    sh_d    = sh_q << 1;
                end else if (rep_q != '0) begin
                    state_d  = ST_GAP;
                    rep_d    = rep_q - REP_W'(1);
                    x_d      = 1'b0;
                    valid_d  = 1'b0;
                    gap_load = 1'b1;
                end else begin
                    state_d = ST_DONE;
                    x_d     = 1'b0;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                end
            end

            ST_GAP: begin
                if (gap_zero) begin
                    state_d  = ST_SHIFT;
                    x_d      = pat_q[WIDTH-1];
                    sh_d     = pat_q << 1;
                    valid_d  = 1'b1;
                    bit_load = 1'b1;
                end else begin
                    gap_dec = 1'b1;
                end
            end

            ST_DONE: begin
                // start is not looked at here: a held start relaunches from IDLE.
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                x_d     = 1'b0;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, latched fields and registered outputs; reset wins over everything.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            sh_q    <= '0;
            len_q   <= '0;
            rep_q   <= '0;
            x_q     <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            sh_q    <= sh_d;
            len_q   <= len_d;
            rep_q   <= rep_d;
            x_q     <= x_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign x_o     = x_q;
    assign valid_o = valid_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign s_o     = state_q;

endmodule

// File: doc/seq_gen.md
SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 Parameter WIDTH, default 8, maximum pattern length in bits.
REQ-002 Parameter GAP_CYCLES, default 1, idle cycles (x=0, valid=0) between repeated transmissions; legal range 1..15.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RESET  input  1  synchronous, active-low reset, sampled on rising CLK edge.
REQ-005 start  input  1  request to transmit; honoured only in IDLE.
REQ-006 pattern  input  WIDTH  bits to send; field pattern[len-1:0], sent MSB first.
REQ-007 len  input  4  number of bits to send; 0 = nothing, values above WIDTH clamp to WIDTH.
REQ-008 repeat  input  4  extra transmissions after the first; total transmissions = repeat+1.
REQ-009 x  output  1  serial bit stream, registered.
REQ-010 valid  output  1  high on every cycle x carries a pattern bit.
REQ-011 busy  output  1  high in SHIFT, GAP and DONE.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 S  output  3  current state code.

Function
REQ-014 States SHALL be IDLE=3'd0, SHIFT=3'd1, GAP=3'd2, DONE=3'd3; codes 4-7 SHALL recover to IDLE on the next edge.
REQ-015 IDLE: x=0, valid=0, busy=0, done=0; start=1 at edge k latches pattern, clamped len and repeat.
REQ-016 If latched len>0, edge k SHALL enter SHIFT with x=pattern[len-1] and valid=1 visible after edge k.
REQ-017 SHIFT: each edge advances one bit, MSB to LSB; bit i (i=0..len-1) visible after edge k+i.
REQ-018 After the last bit, if the remaining repeat count is >0: enter GAP, decrement it, and hold x=0, valid=0 for exactly GAP_CYCLES cycles, then re-enter SHIFT at bit len-1.
REQ-019 After the last bit with repeat count 0: enter DONE. DONE SHALL last one cycle with done=1, x=0, valid=0, then return to IDLE.
REQ-020 If latched len=0, edge k SHALL enter DONE directly; valid SHALL never assert.
REQ-021 start while busy=1 SHALL be ignored; inputs pattern/len/repeat SHALL be ignored outside the latching edge.
REQ-022 start held high across DONE→IDLE SHALL launch a new transmission on the first IDLE edge (no back-to-back from DONE).
REQ-023 Bit index and gap counters SHALL be internal down-counters wide enough for WIDTH and GAP_CYCLES; no wrap-around is permitted.

Reset
REQ-024 RESET=0 at any edge SHALL force S=IDLE, x=0, valid=0, busy=0, done=0, and clear all counters and latched fields.
REQ-025 Reset mid-transmission SHALL abort without a done pulse; RESET takes priority over start.

Structure
REQ-026 Package seq_gen_pkg SHALL hold the state codes and the state-width constant (3).
REQ-027 Sub-module seq_down_counter (loadable, decrement, zero flag) SHALL be used for the bit index and gap count.
REQ-028 Outputs SHALL be driven from registers only; no combinational path from input to output.

Verification
REQ-029 pattern=8'h0D, len=4, repeat=0, start at edge k -> x=1,1,0,1 after edges k..k+3, valid=1 on those cycles, done=1 after k+4, S=0 after k+5.
REQ-030 pattern=8'h0D, len=4, repeat=1, GAP_CYCLES=1 -> x/valid stream 1101, one cycle of valid=0, 1101, then a single done pulse.
REQ-031 len=0, start=1 -> S=3 and done=1 after the latching edge, valid never high, S=0 on the next edge.
REQ-032 pattern=8'hA5, len=12 (clamped to 8) -> x=1,0,1,0,0,1,0,1; start pulsed mid-stream -> no effect on stream or length.
REQ-033 RESET=0 after 2 bits of an 8-bit stream -> after that edge S=0, x=0, valid=0, busy=0, done never asserted.
REQ-034 Loopback: feed x into the team's sequence detector with CLK shared and check the detector's F response against the transmitted pattern.
